// File: rtl/lcd_bus_arbiter.sv
// lcd_bus_arbiter: round-robin arbiter that lets several byte writers share a
// parallel LCD bus. It also runs the LCD power-up reset and wake sequence, and
// shapes each accepted byte into a setup / strobe / hold write cycle.
module lcd_bus_arbiter #(
    parameter int NUM_REQ      = 3,
    parameter int RESET_CYCLES = 120,
    parameter int WAKE_CYCLES  = 1200,
    parameter int SETUP_CYCLES = 1,
    parameter int PULSE_CYCLES = 6,
    parameter int HOLD_CYCLES  = 2
) (
    input  logic                   clk_i,
    input  logic                   reset_n_i,
    input  logic [NUM_REQ-1:0]     req_valid_i,
    input  logic [8*NUM_REQ-1:0]   req_data_i,
    output logic [NUM_REQ-1:0]     req_ready_o,
    input  logic                   lcd_reset_req_i,
    output logic [7:0]             lcd_data_o,
    output logic                   lcd_reset_o,
    output logic                   lcd_enable_o,
    output logic                   busy_o
);

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int IDX_W   = $clog2(NUM_REQ);
    localparam int MAX_CYC = max2(max2(max2(RESET_CYCLES, WAKE_CYCLES),
                                       max2(SETUP_CYCLES, PULSE_CYCLES)),
                                  HOLD_CYCLES);
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    typedef enum logic [2:0] {
        S_RESET  = 3'd0,
        S_WAKE   = 3'd1,
        S_IDLE   = 3'd2,
        S_SETUP  = 3'd3,
        S_STROBE = 3'd4,
        S_HOLD   = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [7:0]         data_q, data_d;
    logic [IDX_W-1:0]   last_grant_q, last_grant_d;

    logic               grant_found;
    logic [IDX_W-1:0]   grant_idx;
    logic               accept;
    logic               cnt_last;

    // Every timed state leaves when its counter reaches 1, so a state loaded
    // with N lasts exactly N cycles.
    assign cnt_last = (cnt_q == CNT_W'(1));

    // Round-robin search: first valid requester after the last winner, wrapping.
    always_comb begin
        logic [IDX_W:0] cand;
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = {1'b0, last_grant_q} + (IDX_W+1)'(k);
            if (cand >= (IDX_W+1)'(NUM_REQ)) begin
                cand = cand - (IDX_W+1)'(NUM_REQ);
            end
            if (!grant_found && req_valid_i[cand[IDX_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[IDX_W-1:0];
            end
        end
    end

    // A transfer happens only in IDLE, and a pending LCD reset request wins over any write.
    assign accept = (state_q == S_IDLE) && !lcd_reset_req_i && grant_found;

    // One-hot accept strobe back to the winning requester.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
            assign req_ready_o[gi] = accept && (grant_idx == IDX_W'(gi));
        end
    endgenerate

    // State register together with the shared counter, the data latch and the round-robin pointer.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q      <= S_RESET;
            cnt_q        <= CNT_W'(RESET_CYCLES);
            data_q       <= 8'h00;
            last_grant_q <= IDX_W'(NUM_REQ - 1);
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            data_q       <= data_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Next-state logic: sequence the timed states and load the counter on each entry.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        data_d       = data_q;
        last_grant_d = last_grant_q;
        case (state_q)
            S_RESET: begin
                if (cnt_last) begin
                    state_d = S_WAKE;
                    cnt_d   = CNT_W'(WAKE_CYCLES);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_WAKE: begin
                if (cnt_last) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_IDLE: begin
                if (lcd_reset_req_i) begin
                    state_d = S_RESET;
                    cnt_d   = CNT_W'(RESET_CYCLES);
                end else if (accept) begin
                    state_d      = S_SETUP;
                    cnt_d        = CNT_W'(SETUP_CYCLES);
                    data_d       = req_data_i[8*grant_idx +: 8];
                    last_grant_d = grant_idx;
                end
            end
            S_SETUP: begin
                if (cnt_last) begin
                    state_d = S_STROBE;
                    cnt_d   = CNT_W'(PULSE_CYCLES);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_STROBE: begin
                if (cnt_last) begin
                    state_d = S_HOLD;
                    cnt_d   = CNT_W'(HOLD_CYCLES);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_HOLD: begin
                if (cnt_last) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = S_RESET;
                cnt_d   = CNT_W'(RESET_CYCLES);
            end
        endcase
    end

    // Outputs decoded from the state alone, so an asynchronous reset drops the strobe at once.
    always_comb begin
        lcd_reset_o  = (state_q == S_RESET);
        lcd_enable_o = (state_q == S_STROBE);
        busy_o       = (state_q != S_IDLE);
        lcd_data_o   = data_q;
    end

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// Testbench for lcd_bus_arbiter. The reference model works on a timeline: it
// records the cycle on which each reset sequence or write began and derives
// every expected output from those timestamps.
module tb_lcd_bus_arbiter;

    localparam int N = 3;
    localparam int R = 4;
    localparam int W = 3;
    localparam int S = 1;
    localparam int P = 2;
    localparam int H = 1;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   valid;
    logic [8*N-1:0] data;
    logic           rreq;
    logic [N-1:0]   ready;
    logic [7:0]     ldata;
    logic           lrst;
    logic           len;
    logic           busy;

    always #5 clk = ~clk;

    lcd_bus_arbiter #(
        .NUM_REQ(N), .RESET_CYCLES(R), .WAKE_CYCLES(W),
        .SETUP_CYCLES(S), .PULSE_CYCLES(P), .HOLD_CYCLES(H)
    ) dut (
        .clk_i(clk), .reset_n_i(rst_n), .req_valid_i(valid), .req_data_i(data),
        .req_ready_o(ready), .lcd_reset_req_i(rreq), .lcd_data_o(ldata),
        .lcd_reset_o(lrst), .lcd_enable_o(len), .busy_o(busy)
    );

    int total = 0;
    int bad   = 0;
    int c     = 0;

    // Timeline model
    int         m_rst_start = 1;
    int         m_idle_from = 1 + R + W;
    int         m_en_from   = -10;
    int         m_en_to     = -20;
    int         m_last      = N - 1;
    logic [7:0] m_data      = 8'h00;
    bit         acc_flag;
    int         acc_idx;
    int         acc_cycles[$];
    int         acc_ids[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, c, obs, exp);
        end
    endtask

    function automatic int rr_pick(input int last, input logic [N-1:0] v);
        for (int k = 1; k <= N; k++) begin
            if (v[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    // One clock cycle: check outputs mid-cycle, advance the model, then step past the edge.
    task automatic cycle();
        logic [N-1:0] e_ready;
        logic         e_rst, e_en, e_busy;
        logic [7:0]   e_data;
        int           w;
        @(negedge clk);
        acc_flag = 1'b0;
        e_ready  = '0;
        w        = -1;
        if (!rst_n) begin
            e_rst = 1'b1; e_en = 1'b0; e_busy = 1'b1; e_data = 8'h00;
        end else begin
            e_rst  = (c < m_rst_start + R);
            e_en   = (c >= m_en_from) && (c <= m_en_to);
            e_busy = (c < m_idle_from);
            e_data = m_data;
            if (!e_busy && !rreq) begin
                w = rr_pick(m_last, valid);
                if (w >= 0) e_ready = N'(1 << w);
            end
        end
        chk("ready",  32'(ready), 32'(e_ready));
        chk("reset",  32'(lrst),  32'(e_rst));
        chk("enable", 32'(len),   32'(e_en));
        chk("busy",   32'(busy),  32'(e_busy));
        chk("data",   32'(ldata), 32'(e_data));
        if (!rst_n) begin
            m_rst_start = c + 1;
            m_idle_from = c + 1 + R + W;
            m_en_from   = -10;
            m_en_to     = -20;
            m_data      = 8'h00;
            m_last      = N - 1;
        end else if (!e_busy) begin
            if (rreq) begin
                m_rst_start = c + 1;
                m_idle_from = c + 1 + R + W;
            end else if (w >= 0) begin
                m_data      = data[w*8 +: 8];
                m_last      = w;
                m_en_from   = c + 1 + S;
                m_en_to     = c + S + P;
                m_idle_from = c + 1 + S + P + H;
                acc_flag    = 1'b1;
                acc_idx     = w;
                acc_cycles.push_back(c);
                acc_ids.push_back(w);
            end
        end
        @(posedge clk);
        #1;
        c++;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (c < m_idle_from && n < 60) begin
            cycle();
            n++;
        end
        chk("wait_idle", 32'(c >= m_idle_from), 32'd1);
    endtask

    task automatic wait_accept();
        int n = 0;
        acc_flag = 1'b0;
        while (!acc_flag && n < 60) begin
            cycle();
            n++;
        end
        chk("wait_accept", 32'(acc_flag), 32'd1);
    endtask

    initial begin
        int rel;
        int t;
        int n;
        int base;
        int exp_ids[4];
        exp_ids = '{0, 1, 2, 0};
        rst_n = 1'b0; valid = '0; data = '0; rreq = 1'b0;
        @(posedge clk);
        #1;
        repeat (3) cycle();

        // Release with all three requesters valid: grants 0,1,2,0 spaced 1+S+P+H.
        rst_n = 1'b1;
        rel   = c;
        valid = 3'b111;
        data  = {8'h33, 8'h22, 8'h11};
        base  = acc_ids.size();
        n = 0;
        while (acc_ids.size() < base + 4 && n < 60) begin
            cycle();
            n++;
        end
        valid = '0;
        chk("rr_count", 32'(acc_ids.size() - base), 32'd4);
        if (acc_ids.size() >= base + 4) begin
            chk("first_grant_cycle", 32'(acc_cycles[base]), 32'(rel + R + W));
            for (int i = 0; i < 4; i++) begin
                chk("rr_order", 32'(acc_ids[base + i]), 32'(exp_ids[i]));
            end
            for (int i = 1; i < 4; i++) begin
                chk("rr_spacing", 32'(acc_cycles[base + i] - acc_cycles[base + i - 1]), 32'(1 + S + P + H));
            end
        end
        wait_idle();

        // Only requester 1 valid with 0xA5; valid drops after the accept.
        valid = 3'b010;
        data  = {8'($urandom), 8'hA5, 8'($urandom)};
        wait_accept();
        chk("single_winner", 32'(acc_idx), 32'd1);
        valid = '0;
        repeat (6) cycle();

        // Reset request and requester 0 in the same IDLE cycle.
        wait_idle();
        rreq  = 1'b1;
        valid = 3'b001;
        data  = {8'h33, 8'h22, 8'h5C};
        t     = c;
        cycle();
        rreq = 1'b0;
        wait_accept();
        chk("grant_after_rereset", 32'(acc_cycles[acc_cycles.size() - 1]), 32'(t + 1 + R + W));
        valid = '0;

        // Asynchronous reset during STROBE.
        wait_idle();
        valid = 3'b001;
        data  = 24'($urandom);
        wait_accept();
        valid = '0;
        n = 0;
        while (c < m_en_from && n < 20) begin
            cycle();
            n++;
        end
        chk("reach_strobe", 32'(len), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_enable", 32'(len), 32'd0);
        chk("async_reset", 32'(lrst), 32'd1);
        chk("async_data", 32'(ldata), 32'd0);
        cycle();
        rst_n = 1'b1;
        repeat (R + W + 2) cycle();

        // Reset request during HOLD is ignored.
        wait_idle();
        valid = 3'b100;
        data  = 24'($urandom);
        wait_accept();
        valid = '0;
        n = 0;
        while (c <= m_en_to && n < 20) begin
            cycle();
            n++;
        end
        rreq = 1'b1;
        cycle();
        rreq = 1'b0;
        repeat (3) cycle();

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            valid = N'($urandom);
            data  = 24'($urandom);
            rreq  = ($urandom_range(0, 19) == 0);
            rst_n = ($urandom_range(0, 99) != 0);
            cycle();
        end
        rst_n = 1'b1; rreq = 1'b0; valid = '0;
        repeat (R + W + 2) cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lcd_bus_arbiter.md
LCD_BUS_ARBITER -- requirements
Module: lcd_bus_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 3, number of byte-write requesters (2..8).
REQ-002 SHALL have parameter RESET_CYCLES, default 120, cycles lcd_reset_o is held high per reset sequence (>=1).
REQ-003 SHALL have parameter WAKE_CYCLES, default 1200, cycles waited after lcd_reset_o falls before the first grant (>=1).
REQ-004 SHALL have parameter SETUP_CYCLES, default 1, data-valid cycles before enable rises (>=1).
REQ-005 SHALL have parameter PULSE_CYCLES, default 6, enable-high cycles (>=1).
REQ-006 SHALL have parameter HOLD_CYCLES, default 2, data-hold cycles after enable falls (>=1).
REQ-007 SHALL have port clk_i, input, 1, sole clock; all state on rising edge.
REQ-008 SHALL have port reset_n_i, input, 1, reset, asynchronous, active-low.
REQ-009 SHALL have port req_valid_i, input, NUM_REQ, bit i = requester i offers a byte.
REQ-010 SHALL have port req_data_i, input, 8*NUM_REQ, byte i at bits [8i+7:8i].
REQ-011 SHALL have port req_ready_o, output, NUM_REQ, one-hot grant/accept strobe.
REQ-012 SHALL have port lcd_reset_req_i, input, 1, request to rerun the LCD reset sequence.
REQ-013 SHALL have port lcd_data_o, output, 8, byte driven to the LCD.
REQ-014 SHALL have port lcd_reset_o, output, 1, active-high LCD reset.
REQ-015 SHALL have port lcd_enable_o, output, 1, LCD write strobe.
REQ-016 SHALL have port busy_o, output, 1, high whenever state is not IDLE.

Function
REQ-017 SHALL implement states RESET, WAKE, IDLE, SETUP, STROBE, HOLD with one shared down-counter.
REQ-018 RESET: lcd_reset_o=1 for exactly RESET_CYCLES cycles, then WAKE.
REQ-019 WAKE: lcd_reset_o=0, enable=0 for exactly WAKE_CYCLES cycles, then IDLE.
REQ-020 IDLE: if lcd_reset_req_i=1, go to RESET next cycle, no grant that cycle (reset request beats writes).
REQ-021 IDLE, no reset request, any req_valid_i set: combinationally assert req_ready_o for exactly one winner; transfer occurs that cycle.
REQ-022 Winner SHALL be round-robin: first valid index searching upward (with wrap) from last_grant+1; last_grant updates on each transfer.
REQ-023 req_ready_o SHALL be all-zero in every state except IDLE and SHALL never be asserted to a requester with valid=0.
REQ-024 On transfer, the winner's byte SHALL be registered into lcd_data_o at that edge; next state SETUP.
REQ-025 SETUP SETUP_CYCLES, STROBE (lcd_enable_o=1) PULSE_CYCLES, HOLD HOLD_CYCLES, then IDLE; back-to-back accept period = 1+SETUP+PULSE+HOLD cycles.
REQ-026 lcd_data_o SHALL remain stable from transfer edge through end of HOLD and hold its last value in IDLE/RESET/WAKE.
REQ-027 lcd_enable_o SHALL be 1 only in STROBE; lcd_reset_o 1 only in RESET.
REQ-028 lcd_reset_req_i outside IDLE SHALL be ignored (not latched); an in-progress write always completes.
REQ-029 Requesters whose valid drops before grant SHALL simply lose arbitration; no state retained for them.

Reset
REQ-030 While reset_n_i=0: state=RESET with counter loaded to RESET_CYCLES, lcd_reset_o=1, lcd_enable_o=0, lcd_data_o=8'h00, req_ready_o=0, busy_o=1, last_grant=NUM_REQ-1.
REQ-031 Reset deassertion mid-write SHALL restart the full RESET/WAKE sequence; no partial strobe appears.

Verification (NUM_REQ=3, RESET=4, WAKE=3, SETUP=1, PULSE=2, HOLD=1)
REQ-032 Release reset -> lcd_reset_o high 4 cycles, low; first req_ready_o possible 3 cycles later; busy_o low from then.
REQ-033 Only req 1 valid, data 8'hA5 -> ready_o=3'b010 one cycle; data=A5 next cycle; enable high exactly 2 cycles after 1 setup cycle; IDLE after 1 hold cycle.
REQ-034 All three valid continuously, bytes 11/22/33 -> grants 0,1,2,0 in order, accepts exactly 5 cycles apart.
REQ-035 lcd_reset_req_i and req 0 valid same IDLE cycle -> no grant, lcd_reset_o high 4 cycles, then WAKE, then req 0 granted.
REQ-036 reset_n_i pulsed low during STROBE -> enable falls immediately, data=00, full sequence restarts; lcd_reset_req_i pulsed during HOLD -> ignored.
